// File: rtl/fft4_input_framer_pkg.sv
// -----------------------------------------------------------------------------
// fft4_input_framer_pkg
// Shared constants and helpers for the 4-point FFT input framing path.
//   NB_DATA_DEFAULT : default width of each signed real/imag component
//   FFT4_N          : points per frame
//   FFT4_IDX_W      : width of a sample index within a frame
//   idx_t           : sample index type
//   bitrev2()       : 2-bit bit reversal used by the DIT lane ordering
// -----------------------------------------------------------------------------
package fft4_input_framer_pkg;

  localparam int NB_DATA_DEFAULT = 8;
  localparam int FFT4_N          = 4;
  localparam int FFT4_IDX_W      = 2;

  typedef logic [FFT4_IDX_W-1:0] idx_t;

  function automatic idx_t bitrev2(input idx_t idx);
    return {idx[0], idx[1]};
  endfunction

endpackage

// File: rtl/fft4_frame_bank.sv
// -----------------------------------------------------------------------------
// fft4_frame_bank
// One frame of complex storage: FFT4_N registered (real, imag) slots, written
// one slot per cycle at i_idx when i_we is high. Contents persist until
// overwritten; the owner decides when the bank counts as full.
// Ports:
//   i_clk, i_rst_n       : clock, asynchronous active-low reset (clears slots)
//   i_we, i_idx          : write enable and slot index
//   i_data_r, i_data_i   : sample to store
//   o_data_r, o_data_i   : all FFT4_N slots, slot k at element [k]
// -----------------------------------------------------------------------------
module fft4_frame_bank
  import fft4_input_framer_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEFAULT
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_we,
  input  idx_t                               i_idx,
  input  logic [NB_DATA-1:0]                 i_data_r,
  input  logic [NB_DATA-1:0]                 i_data_i,
  output logic [FFT4_N-1:0][NB_DATA-1:0]     o_data_r,
  output logic [FFT4_N-1:0][NB_DATA-1:0]     o_data_i
);

  logic [FFT4_N-1:0][NB_DATA-1:0] data_r_q, data_r_d;
  logic [FFT4_N-1:0][NB_DATA-1:0] data_i_q, data_i_d;

  // NOTE: next-state starts as a copy of the current state so every path
  // assigns every bit; without it this block would infer latches.
  always_comb begin
    data_r_d = data_r_q;
    data_i_d = data_i_q;
    if (i_we) begin
      data_r_d[i_idx] = i_data_r;
      data_i_d[i_idx] = i_data_i;
    end
  end

  // NOTE: storage is reset on purpose: the output lanes must read zero out of
  // reset, so this is a register bank, not a RAM that could skip the reset.
  // NOTE: non-blocking assignments here so all flops sample pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_r_q <= '0;
      data_i_q <= '0;
    end else begin
      data_r_q <= data_r_d;
      data_i_q <= data_i_d;
    end
  end

  assign o_data_r = data_r_q;
  assign o_data_i = data_i_q;

endmodule

// File: rtl/fft4_input_framer.sv
// -----------------------------------------------------------------------------
// fft4_input_framer
// Groups four consecutive complex samples into a frame and presents the frame
// on four parallel lanes. Two frame banks ping-pong so the input can stream at
// one sample per clock while the downstream butterfly stage stalls.
// Ports:
//   i_clk, i_rst_n               : clock, asynchronous active-low reset
//   i_valid, i_sof               : sample valid, start-of-frame (sample 0)
//   i_data_r, i_data_i           : signed input sample
//   o_ready                      : a sample can be accepted this cycle
//   o_valid, i_ready             : output frame handshake
//   o_data{0..3}_r/_i            : frame lanes
//   o_align_err                  : one-cycle pulse, i_sof hit a partial frame
// Build option:
//   FFT4_FRAMER_BITREV_EN defined -> samples land at bit-reversed slots
//   (lanes carry s0, s2, s1, s3); undefined -> lane k carries sample k.
// -----------------------------------------------------------------------------
module fft4_input_framer
  import fft4_input_framer_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEFAULT
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  input  logic                      i_sof,
  input  logic signed [NB_DATA-1:0] i_data_r,
  input  logic signed [NB_DATA-1:0] i_data_i,
  output logic                      o_ready,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic signed [NB_DATA-1:0] o_data0_r,
  output logic signed [NB_DATA-1:0] o_data1_r,
  output logic signed [NB_DATA-1:0] o_data2_r,
  output logic signed [NB_DATA-1:0] o_data3_r,
  output logic signed [NB_DATA-1:0] o_data0_i,
  output logic signed [NB_DATA-1:0] o_data1_i,
  output logic signed [NB_DATA-1:0] o_data2_i,
  output logic signed [NB_DATA-1:0] o_data3_i,
  output logic                      o_align_err
);

  logic [1:0] full_q, full_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  idx_t       idx_q, idx_d;
  logic       align_err_q, align_err_d;

  logic       accept;
  logic       xfer;
  idx_t       idx_eff;
  idx_t       wr_pos;
  logic [1:0] bank_we;

  logic [FFT4_N-1:0][NB_DATA-1:0] bank_r [2];
  logic [FFT4_N-1:0][NB_DATA-1:0] bank_i [2];
  logic [FFT4_N-1:0][NB_DATA-1:0] lane_r;
  logic [FFT4_N-1:0][NB_DATA-1:0] lane_i;

  // Ready depends only on registered flags, so a bank freed by a transfer
  // is offered to the input one cycle later and i_ready never reaches o_ready.
  assign o_ready     = ~(full_q[0] & full_q[1]);
  assign o_valid     = full_q[rd_bank_q];
  assign o_align_err = align_err_q;

  always_comb begin
    accept  = i_valid & o_ready;
    xfer    = o_valid & i_ready;
    // A start-of-frame always restarts the current bank at slot 0, dropping
    // whatever partial frame was there.
    idx_eff = i_sof ? '0 : idx_q;
`ifdef FFT4_FRAMER_BITREV_EN
    wr_pos  = bitrev2(idx_eff);
`else
    wr_pos  = idx_eff;
`endif
    bank_we = '0;
    bank_we[wr_bank_q] = accept;
  end

  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    idx_d       = idx_q;
    align_err_d = accept & i_sof & (idx_q != '0);

    // The write bank is never full while o_ready is high, so a transfer
    // clear and a completion set always hit different banks.
    if (xfer) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    if (accept) begin
      idx_d = idx_eff + idx_t'(1);
      if (idx_eff == idx_t'(FFT4_N - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        idx_d             = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      idx_q       <= '0;
      align_err_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      idx_q       <= idx_d;
      align_err_q <= align_err_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft4_frame_bank #(
      .NB_DATA (NB_DATA)
    ) u_bank (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_we     (bank_we[b]),
      .i_idx    (wr_pos),
      .i_data_r (i_data_r),
      .i_data_i (i_data_i),
      .o_data_r (bank_r[b]),
      .o_data_i (bank_i[b])
    );
  end

  // Lanes follow the registered read-bank select, so they hold steady
  // while a frame waits for i_ready.
  assign lane_r = bank_r[rd_bank_q];
  assign lane_i = bank_i[rd_bank_q];

  assign o_data0_r = lane_r[0];
  assign o_data1_r = lane_r[1];
  assign o_data2_r = lane_r[2];
  assign o_data3_r = lane_r[3];
  assign o_data0_i = lane_i[0];
  assign o_data1_i = lane_i[1];
  assign o_data2_i = lane_i[2];
  assign o_data3_i = lane_i[3];

endmodule

// File: tb/tb_fft4_input_framer.sv
// -----------------------------------------------------------------------------
// tb_fft4_input_framer
// Self-checking bench for fft4_input_framer. A frame-level reference model
// (queue of completed frames plus a partial-frame buffer) predicts ready,
// valid, alignment error and lane contents; a negedge process compares them
// every cycle. Directed scenarios add literal expectations, then a randomized
// run exercises stalls, realignment and back-to-back traffic.
// Honours FFT4_FRAMER_BITREV_EN for the expected lane ordering.
// -----------------------------------------------------------------------------
module tb_fft4_input_framer;

  localparam int NB = 8;

  logic                 clk;
  logic                 rst_n;
  logic                 i_valid, i_sof, i_ready;
  logic signed [NB-1:0] i_data_r, i_data_i;
  logic                 o_ready, o_valid, o_align_err;
  logic signed [NB-1:0] o_data0_r, o_data1_r, o_data2_r, o_data3_r;
  logic signed [NB-1:0] o_data0_i, o_data1_i, o_data2_i, o_data3_i;

  fft4_input_framer #(.NB_DATA(NB)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .i_sof       (i_sof),
    .i_data_r    (i_data_r),
    .i_data_i    (i_data_i),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data0_r   (o_data0_r),
    .o_data1_r   (o_data1_r),
    .o_data2_r   (o_data2_r),
    .o_data3_r   (o_data3_r),
    .o_data0_i   (o_data0_i),
    .o_data1_i   (o_data1_i),
    .o_data2_i   (o_data2_i),
    .o_data3_i   (o_data3_i),
    .o_align_err (o_align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [NB-1:0] dut_r [4];
  logic signed [NB-1:0] dut_i [4];
  assign dut_r[0] = o_data0_r;
  assign dut_r[1] = o_data1_r;
  assign dut_r[2] = o_data2_r;
  assign dut_r[3] = o_data3_r;
  assign dut_i[0] = o_data0_i;
  assign dut_i[1] = o_data1_i;
  assign dut_i[2] = o_data2_i;
  assign dut_i[3] = o_data3_i;

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [3:0][NB-1:0] r;
    logic [3:0][NB-1:0] i;
  } frame_t;

  frame_t      frames[$];       // completed frames not yet transferred
  logic [NB-1:0] part_r [4];    // partial frame, in arrival order
  logic [NB-1:0] part_i [4];
  int          part_n;
  bit          m_err;
  int          lane_src [4];    // lane k carries sample lane_src[k]

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs (called at posedge+1), advance the model at
  // the edge, and return just after the edge.
  task automatic cycle(input bit v, input bit s, input logic [NB-1:0] dr,
                       input logic [NB-1:0] di, input bit rdy, output bit acc);
    bit     xf;
    frame_t f;
    i_valid  = v;
    i_sof    = s;
    i_data_r = dr;
    i_data_i = di;
    i_ready  = rdy;
    acc = v && (frames.size() < 2);
    xf  = rdy && (frames.size() > 0);
    @(posedge clk);
    m_err = acc && s && (part_n != 0);
    if (xf) void'(frames.pop_front());
    if (acc) begin
      if (s) part_n = 0;
      part_r[part_n] = dr;
      part_i[part_n] = di;
      part_n++;
      if (part_n == 4) begin
        for (int k = 0; k < 4; k++) begin
          f.r[k] = part_r[lane_src[k]];
          f.i[k] = part_i[lane_src[k]];
        end
        frames.push_back(f);
        part_n = 0;
      end
    end
    #1;
  endtask

  task automatic cyc(input bit v, input bit s, input int dr, input int di, input bit rdy);
    bit acc;
    cycle(v, s, 8'(dr), 8'(di), rdy, acc);
  endtask

  // Assert reset at posedge+1, check the async-cleared outputs, release later.
  task automatic do_reset();
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_ready = 1'b0;
    frames.delete();
    part_n  = 0;
    m_err   = 1'b0;
    #1;
    check("rst_valid", int'(o_valid), 0);
    check("rst_ready", int'(o_ready), 1);
    check("rst_align_err", int'(o_align_err), 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_lane%0d_r", k), int'(dut_r[k]), 0);
      check($sformatf("rst_lane%0d_i", k), int'(dut_i[k]), 0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------- compare
  always @(negedge clk) begin
    check("o_ready", int'(o_ready), int'(frames.size() < 2));
    check("o_valid", int'(o_valid), int'(frames.size() > 0));
    check("o_align_err", int'(o_align_err), int'(m_err));
    if (frames.size() > 0) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("lane%0d_r", k), int'(dut_r[k]), int'($signed(frames[0].r[k])));
        check($sformatf("lane%0d_i", k), int'(dut_i[k]), int'($signed(frames[0].i[k])));
      end
    end
  end

  // ---------------------------------------------------------- stimulus
  initial begin
    bit acc;
    int pulses;
    int exp_lane [4];
`ifdef FFT4_FRAMER_BITREV_EN
    lane_src = '{0, 2, 1, 3};
`else
    lane_src = '{0, 1, 2, 3};
`endif
    for (int k = 0; k < 4; k++) exp_lane[k] = lane_src[k] + 1;

    rst_n = 1'b1; i_valid = 0; i_sof = 0; i_ready = 0; i_data_r = 0; i_data_i = 0;
    part_n = 0; m_err = 0;
    #2;
    do_reset();

    // Single frame, consumer ready: valid for one cycle after the 4th sample.
    for (int s = 1; s <= 4; s++) cyc(1, s == 1, s, -s, 1);
    check("t1_valid", int'(o_valid), 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_lane%0d_r", k), int'(dut_r[k]), exp_lane[k]);
      check($sformatf("t1_lane%0d_i", k), int'(dut_i[k]), -exp_lane[k]);
    end
    cyc(0, 0, 0, 0, 1);
    check("t1_valid_drop", int'(o_valid), 0);

    // Both banks fill while stalled; consumer then drains frames in order.
    do_reset();
    for (int s = 1; s <= 8; s++) cyc(1, s == 1, s, -s, 0);
    check("t2_ready_low", int'(o_ready), 0);
    for (int c = 0; c < 5; c++) begin
      cycle(1, 0, 8'(9), 8'(-9), 0, acc);
      check("t2_stall_no_accept", int'(acc), 0);
    end
    check("t2_frame1_lane0", int'(o_data0_r), 1);
    cyc(0, 0, 0, 0, 1);
    check("t2_frame2_lane0", int'(o_data0_r), 5);
    for (int s = 9; s <= 12; s++) begin
      int guard = 0;
      do begin
        cycle(1, 0, 8'(s), 8'(-s), 1, acc);
        guard++;
      end while (!acc && guard < 10);
      check("t2_accept_bound", int'(acc), 1);
    end
    repeat (3) cyc(0, 0, 0, 0, 1);

    // Continuous stream: four frames, one valid pulse every four cycles.
    do_reset();
    pulses = 0;
    for (int s = 0; s < 16; s++) begin
      cyc(1, (s % 4) == 0, 20 + s, -(20 + s), 1);
      if (o_valid) pulses++;
      check("t3_ready_high", int'(o_ready), 1);
    end
    check("t3_pulses", pulses, 4);
    cyc(0, 0, 0, 0, 1);

    // Realignment: sof after two samples restarts the frame at lane 0.
    do_reset();
    cyc(1, 1, 5, -5, 1);
    cyc(1, 0, 6, -6, 1);
    cyc(1, 1, 9, -9, 1);
    check("t4_align_err", int'(o_align_err), 1);
    cyc(1, 0, 10, -10, 1);
    check("t4_align_err_pulse", int'(o_align_err), 0);
    cyc(1, 0, 11, -11, 1);
    cyc(1, 0, 12, -12, 1);
    check("t4_valid", int'(o_valid), 1);
    check("t4_lane0_r", int'(o_data0_r), 9);
    cyc(0, 0, 0, 0, 1);

    // Reset with a full bank pending and a partial frame in progress.
    do_reset();
    for (int s = 1; s <= 7; s++) cyc(1, s == 1, s, s, 0);
    do_reset();
    for (int s = 0; s < 4; s++) cyc(1, 0, 10 + s, 30 + s, 1);
    check("t5_valid", int'(o_valid), 1);
    for (int k = 0; k < 4; k++)
      check($sformatf("t5_lane%0d_r", k), int'(dut_r[k]), 9 + exp_lane[k]);
    cyc(0, 0, 0, 0, 1);

    // Randomized traffic with stalls, stray sofs and idle cycles.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
            8'($urandom), 8'($urandom), $urandom_range(0, 9) < 6, acc);
    end
    repeat (6) cyc(0, 0, 0, 0, 1);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
